// File: rtl/button_mode_select.sv
// Up/down push-button mode selector: per-button synchroniser, debouncer and
// hold/auto-repeat FSM stepping a bounded mode index with wrap or saturate.
module button_mode_select #(
   parameter int NUM_MODES       = 4,
   parameter int RESET_SEL       = 0,
   parameter int WRAP            = 1,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000,
   localparam int SEL_W          = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   output logic [SEL_W-1:0] sel,
   output logic             sel_changed,
   output logic             btn_up_db,
   output logic             btn_down_db
);

   localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HR_MAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HR_W      = (HR_MAX > 1) ? $clog2(HR_MAX) : 1;
   localparam int HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
   localparam int REP_LAST  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_MODES - 1);

   typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

   logic [1:0] raw;
   logic [1:0] db;
   logic [1:0] step;

   assign raw = {btn_down, btn_up};

   genvar i;
   generate
      for (i = 0; i < 2; i++) begin : g_btn
         logic            sync_a;
         logic            sync_b;
         logic            db_q;
         logic [DB_W-1:0] db_cnt;
         state_t          state;
         logic [HR_W-1:0] hr_cnt;
         logic            step_req;

         // Two-flop synchroniser followed by the stable-level debouncer
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_a <= 1'b0;
               sync_b <= 1'b0;
               db_q   <= 1'b0;
               db_cnt <= {DB_W{1'b0}};
            end else begin
               sync_a <= raw[i];
               sync_b <= sync_a;
               if (sync_b == db_q) begin
                  db_cnt <= {DB_W{1'b0}};
               end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                  db_q   <= sync_b;
                  db_cnt <= {DB_W{1'b0}};
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
         end

         // Press / hold / auto-repeat state machine
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state  <= IDLE;
               hr_cnt <= {HR_W{1'b0}};
            end else begin
               case (state)
                  IDLE: begin
                     hr_cnt <= {HR_W{1'b0}};
                     if (db_q) state <= HELD;
                  end
                  HELD: begin
                     if (!db_q) begin
                        state  <= IDLE;
                        hr_cnt <= {HR_W{1'b0}};
                     end else if ((hr_cnt == HR_W'(HOLD_LAST)) && (REPEAT_CYCLES != 0)) begin
                        state  <= REPEAT;
                        hr_cnt <= {HR_W{1'b0}};
                     end else if (hr_cnt != HR_W'(HOLD_LAST)) begin
                        hr_cnt <= hr_cnt + HR_W'(1);
                     end
                  end
                  REPEAT: begin
                     if (!db_q) begin
                        state  <= IDLE;
                        hr_cnt <= {HR_W{1'b0}};
                     end else if (hr_cnt == HR_W'(REP_LAST)) begin
                        hr_cnt <= {HR_W{1'b0}};
                     end else begin
                        hr_cnt <= hr_cnt + HR_W'(1);
                     end
                  end
                  default: begin
                     state  <= IDLE;
                     hr_cnt <= {HR_W{1'b0}};
                  end
               endcase
            end
         end

         // IDLE with db high can only mean the level has just risen
         always_comb begin
            step_req = 1'b0;
            case (state)
               IDLE:    step_req = db_q;
               HELD:    step_req = db_q && (hr_cnt == HR_W'(HOLD_LAST)) && (REPEAT_CYCLES != 0);
               REPEAT:  step_req = db_q && (hr_cnt == HR_W'(REP_LAST));
               default: step_req = 1'b0;
            endcase
         end

         assign db[i]   = db_q;
         assign step[i] = step_req;
      end
   endgenerate

   assign btn_up_db   = db[0];
   assign btn_down_db = db[1];

   logic [SEL_W-1:0] sel_next;

   // Next index; coincident up and down requests cancel
   always_comb begin
      sel_next = sel;
      case (step)
         2'b01: begin
            if (sel != SEL_LAST) begin
               sel_next = sel + SEL_W'(1);
            end else if (WRAP != 0) begin
               sel_next = {SEL_W{1'b0}};
            end else begin
               sel_next = sel;
            end
         end
         2'b10: begin
            if (sel != {SEL_W{1'b0}}) begin
               sel_next = sel - SEL_W'(1);
            end else if (WRAP != 0) begin
               sel_next = SEL_LAST;
            end else begin
               sel_next = sel;
            end
         end
         default: sel_next = sel;
      endcase
   end

   // Index register and change strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel         <= SEL_W'(RESET_SEL);
         sel_changed <= 1'b0;
      end else begin
         sel         <= sel_next;
         sel_changed <= (sel_next != sel);
      end
   end

endmodule

// File: tb/tb_button_mode_select.sv
// Directed bench for button_mode_select: a wrapping and a saturating instance
// share the same buttons and are checked against per-edge expected values.
module tb_button_mode_select;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up;
   logic       btn_down;
   logic [1:0] sel;
   logic       sel_changed;
   logic       up_db;
   logic       down_db;
   logic [1:0] sat_sel;
   logic       sat_changed;
   logic       sat_up_db;
   logic       sat_down_db;

   int n_checks = 0;
   int n_pass   = 0;
   int model_sel;
   int model_sat;

   always #5 clk = ~clk;

   button_mode_select #(
      .NUM_MODES(3), .RESET_SEL(0), .WRAP(1),
      .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .sel(sel), .sel_changed(sel_changed),
      .btn_up_db(up_db), .btn_down_db(down_db)
   );

   button_mode_select #(
      .NUM_MODES(3), .RESET_SEL(0), .WRAP(0),
      .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
   ) dut_sat (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .sel(sat_sel), .sel_changed(sat_changed),
      .btn_up_db(sat_up_db), .btn_down_db(sat_down_db)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic check_idle_state(input string tag);
      check_val({tag, " sel"}, int'(sel), 0);
      check_val({tag, " chg"}, int'(sel_changed), 0);
      check_val({tag, " up_db"}, int'(up_db), 0);
      check_val({tag, " down_db"}, int'(down_db), 0);
      check_val({tag, " sat_sel"}, int'(sat_sel), 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst      = 1'b1;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      #1;
      check_idle_state(tag);
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      model_sel = 0;
      model_sat = 0;
   endtask

   // Caller is at a negedge; the next posedge is edge 0, the first to sample
   // the raw level.  Raw stays high for edges 0..hold-1.
   task automatic run_press(input string tag, input logic up, input logic down,
                            input int hold, input int n, input logic [63:0] steps,
                            input int dir);
      int nxt;
      int exp_chg;
      int exp_sat_chg;
      btn_up   = up;
      btn_down = down;
      for (int e = 0; e < n; e++) begin
         @(posedge clk);
         #1;
         if (e == hold - 1) begin
            btn_up   = 1'b0;
            btn_down = 1'b0;
         end
         exp_chg     = 0;
         exp_sat_chg = 0;
         if (steps[e]) begin
            nxt       = (model_sel + dir + 3) % 3;
            exp_chg   = (nxt != model_sel) ? 1 : 0;
            model_sel = nxt;
            nxt       = model_sat + dir;
            if (nxt < 0) nxt = 0;
            if (nxt > 2) nxt = 2;
            exp_sat_chg = (nxt != model_sat) ? 1 : 0;
            model_sat   = nxt;
         end
         check_val($sformatf("%s e%0d sel", tag, e), int'(sel), model_sel);
         check_val($sformatf("%s e%0d chg", tag, e), int'(sel_changed), exp_chg);
         check_val($sformatf("%s e%0d sat_sel", tag, e), int'(sat_sel), model_sat);
         check_val($sformatf("%s e%0d sat_chg", tag, e), int'(sat_changed), exp_sat_chg);
      end
   endtask

   initial begin
      logic [63:0] m;
      logic [15:0] pat;

      rst      = 1'b1;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      do_reset("reset0");

      // Clean press: step lands on edge 3+4 = 7, nothing on release
      @(negedge clk);
      run_press("t1_up", 1'b1, 1'b0, 6, 16, 64'h80, 1);

      // Bounce never survives 4 stable cycles
      pat = 16'h0037;
      @(negedge clk);
      btn_up = pat[0];
      for (int e = 0; e < 16; e++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("t2_bounce e%0d up_db", e), int'(up_db), 0);
         check_val($sformatf("t2_bounce e%0d sel", e), int'(sel), model_sel);
         check_val($sformatf("t2_bounce e%0d chg", e), int'(sel_changed), 0);
         btn_up = (e < 15) ? pat[e + 1] : 1'b0;
      end

      // Three up presses then one down: wrap instance 1,2,0,2; saturating 1,2,2,1
      do_reset("reset3");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         run_press($sformatf("t3_up%0d", k), 1'b1, 1'b0, 6, 16, 64'h80, 1);
      end
      @(negedge clk);
      run_press("t3_down", 1'b0, 1'b1, 6, 16, 64'h80, -1);

      // Held 40 cycles: press step, first repeat 8 later, then every 4 while db high
      do_reset("reset4");
      m    = 64'h0;
      m[7] = 1'b1;
      for (int t = 15; t <= 43; t += 4) m[t] = 1'b1;
      @(negedge clk);
      run_press("t4_hold", 1'b1, 1'b0, 40, 52, m, 1);

      // Both buttons together: steps cancel
      do_reset("reset5");
      @(negedge clk);
      run_press("t5_both", 1'b1, 1'b1, 6, 16, 64'h80, 0);

      // Reset while auto-repeating at sel=2 with the button still held
      do_reset("reset6");
      m     = 64'h0;
      m[7]  = 1'b1;
      m[15] = 1'b1;
      @(negedge clk);
      run_press("t6_pre", 1'b1, 1'b0, 100, 17, m, 1);
      btn_up = 1'b1;
      rst    = 1'b1;
      #1;
      check_idle_state("t6_async_rst");
      model_sel = 0;
      model_sat = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_press("t6_post", 1'b1, 1'b0, 6, 16, 64'h80, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
